mul_div_unit: RTL and testbench

//  E-stage multiply/divide unit; consumes MDU_Operation from the decode controller plus forwarded rs/rt.

---
 rtl/mul_div_unit_pkg.sv | 63 ++++++
 rtl/mdu_result_calc.sv | 73 +++++++
 rtl/mul_div_unit.sv | 120 ++++++++++++
 tb/tb_mul_div_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit_pkg
//  Description : Shared MDU operation codes, latency defaults, busy-FSM state
//                type and opcode-class helpers for the multiply/divide unit.
//                MDU_MADD_EN adds the multiply-accumulate opcodes to the
//                multi-cycle class.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_div_unit_pkg;

    localparam int MDU_OP_W = 4;
    typedef logic [MDU_OP_W-1:0] mdu_op_t;

    // MDU_Operation codes issued by the decode controller
    localparam mdu_op_t MDU_NOOP  = 4'd0;
    localparam mdu_op_t MDU_READ  = 4'd1;
    localparam mdu_op_t MDU_MTHI  = 4'd2;
    localparam mdu_op_t MDU_MTLO  = 4'd3;
    localparam mdu_op_t MDU_MULT  = 4'd4;
    localparam mdu_op_t MDU_MULTU = 4'd5;
    localparam mdu_op_t MDU_DIV   = 4'd6;
    localparam mdu_op_t MDU_DIVU  = 4'd7;
    localparam mdu_op_t MDU_MADD  = 4'd8;
    localparam mdu_op_t MDU_MADDU = 4'd9;
    localparam mdu_op_t MDU_MSUB  = 4'd10;
    localparam mdu_op_t MDU_MSUBU = 4'd11;

    // Default latencies in busy cycles
    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // Busy counter width; latencies must fit in 1..255
    localparam int MDU_CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    // True for operations that occupy the unit for several cycles
    function automatic logic mdu_is_muldiv(input mdu_op_t op);
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // True for the divide class (selects the divide latency)
    function automatic logic mdu_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // True for any opcode that would change MDU state if accepted
    function automatic logic mdu_is_active(input mdu_op_t op);
        return mdu_is_muldiv(op) || (op == MDU_MTHI) || (op == MDU_MTLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_result_calc.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_result_calc
//  Description : Combinational result path of the MDU. Produces the 64-bit
//                {hi,lo} value for mult/div (and, with MDU_MADD_EN, the
//                multiply-accumulate family) plus a divide-by-zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_result_calc
    import mul_div_unit_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         op_a,
    input  logic [31:0]         op_b,
    input  logic [31:0]         hi,
    input  logic [31:0]         lo,
    output logic [63:0]         result,
    output logic                div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_ovf;
    logic [31:0] w_divisor_s;
    logic [31:0] w_divisor_u;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;

    assign w_prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    assign w_prod_u = {32'd0, op_a} * {32'd0, op_b};

    // 0x80000000 / -1 overflows; dividing by 1 instead yields the
    // architected quotient 0x80000000 with remainder 0, and a zero divisor
    // is replaced so the divider never sees it (result is discarded anyway).
    assign w_div_ovf   = (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign w_divisor_s = ((op_b == 32'd0) || w_div_ovf) ? 32'd1 : op_b;
    assign w_divisor_u = (op_b == 32'd0) ? 32'd1 : op_b;

    assign w_quot_s = $signed(op_a) / $signed(w_divisor_s);
    assign w_rem_s  = $signed(op_a) % $signed(w_divisor_s);
    assign w_quot_u = op_a / w_divisor_u;
    assign w_rem_u  = op_a % w_divisor_u;

    assign div_by_zero = mdu_is_div(op) && (op_b == 32'd0);

`ifndef MDU_MADD_EN
    // The accumulator inputs only feed the multiply-accumulate family
    logic w_unused_acc;
    assign w_unused_acc = ^{hi, lo};
`endif

    // Select the 64-bit {hi,lo} result for the issuing opcode
    always_comb begin
        result = 64'd0;
        case (op)
            MDU_MULT:  result = w_prod_s;
            MDU_MULTU: result = w_prod_u;
            MDU_DIV:   result = {w_rem_s, w_quot_s};
            MDU_DIVU:  result = {w_rem_u, w_quot_u};
`ifdef MDU_MADD_EN
            MDU_MADD:  result = {hi, lo} + w_prod_s;
            MDU_MADDU: result = {hi, lo} + w_prod_u;
            MDU_MSUB:  result = {hi, lo} - w_prod_s;
            MDU_MSUBU: result = {hi, lo} - w_prod_u;
`endif
            default:   result = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : E-stage multiply/divide unit. Holds HI/LO, computes the
//                result at issue into pending registers and models the
//                multi-cycle latency with a busy counter; HI/LO update when
//                the counter expires. Optional macro MDU_MADD_EN enables the
//                MADD/MADDU/MSUB/MSUBU accumulate operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [31:0]         op_a,
    input  logic [31:0]         op_b,
    input  logic                cancel,
    output logic                start,
    output logic                busy,
    output logic [31:0]         hi,
    output logic [31:0]         lo
);

    localparam logic [MDU_CNT_W-1:0] C_MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] C_DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);

    mdu_state_t           r_state;
    logic [MDU_CNT_W-1:0] r_count;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;
    logic                 r_pend_wr;

    logic                 w_accept;
    logic [63:0]          w_result;
    logic                 w_div_zero;
    logic [MDU_CNT_W-1:0] w_latency;

    assign w_accept  = !cancel && !busy;
    assign start     = w_accept && mdu_is_muldiv(mdu_op);
    assign w_latency = mdu_is_div(mdu_op) ? C_DIV_CNT : C_MULT_CNT;

    mdu_result_calc u_calc (
        .op          (mdu_op),
        .op_a        (op_a),
        .op_b        (op_b),
        .hi          (hi),
        .lo          (lo),
        .result      (w_result),
        .div_by_zero (w_div_zero)
    );

    // Busy FSM: capture result at issue, count down, commit to HI/LO on expiry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            busy      <= 1'b0;
            r_count   <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        busy      <= 1'b1;
                        r_count   <= w_latency;
                        r_pend_hi <= w_result[63:32];
                        r_pend_lo <= w_result[31:0];
                        // A zero divisor burns the full latency but leaves HI/LO alone
                        r_pend_wr <= !w_div_zero;
                    end else if (w_accept && (mdu_op == MDU_MTHI)) begin
                        hi <= op_a;
                    end else if (w_accept && (mdu_op == MDU_MTLO)) begin
                        lo <= op_a;
                    end
                end
                ST_RUN: begin
                    if (r_count == MDU_CNT_W'(1)) begin
                        r_state   <= ST_IDLE;
                        busy      <= 1'b0;
                        r_count   <= '0;
                        r_pend_wr <= 1'b0;
                        if (r_pend_wr) begin
                            hi <= r_pend_hi;
                            lo <= r_pend_lo;
                        end
                    end else begin
                        r_count <= r_count - MDU_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Warn when a state-changing op arrives while busy; the hazard unit should have stalled it
    always @(posedge clk) begin
        if (reset && busy && !cancel) begin
            assert (!mdu_is_active(mdu_op))
                else $warning("mul_div_unit: op %0d issued while busy was ignored", mdu_op);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Self-checking bench for mul_div_unit: directed cases plus
//                randomized ops against an arithmetic reference model of
//                HI/LO and the busy latency. Honours MDU_MADD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    typedef longint unsigned u64_t;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mdu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cancel;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    // Architectural HI/LO as the reference model sees them
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mul_div_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mdu_op (mdu_op),
        .op_a   (op_a),
        .op_b   (op_b),
        .cancel (cancel),
        .start  (start),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_is_long(input logic [3:0] op);
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic int op_latency(input logic [3:0] op);
        return (op == MDU_DIV || op == MDU_DIVU) ? DIV_N : MULT_N;
    endfunction

    // Reference semantics written as plain integer arithmetic
    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int     sa, sb;
        longint sp;
        u64_t   ua, ub, acc;
        sa  = a;
        sb  = b;
        ua  = a;
        ub  = b;
        sp  = longint'(sa) * longint'(sb);
        acc = {m_hi, m_lo};
        case (op)
            MDU_MTHI:  m_hi = a;
            MDU_MTLO:  m_lo = a;
            MDU_MULT:  {m_hi, m_lo} = sp;
            MDU_MULTU: {m_hi, m_lo} = ua * ub;
            MDU_DIV: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                end
            end
            MDU_DIVU: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {m_hi, m_lo} = acc + u64_t'(sp);
            MDU_MSUB:  {m_hi, m_lo} = acc - u64_t'(sp);
            MDU_MADDU: {m_hi, m_lo} = acc + ua * ub;
            MDU_MSUBU: {m_hi, m_lo} = acc - ua * ub;
`endif
            default: ;
        endcase
    endtask

    // Issue one op, check start, busy over its whole latency and final HI/LO
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cxl, input string tag);
        logic [31:0] old_hi, old_lo;
        bit          exp_start;
        int          lat;
        old_hi    = m_hi;
        old_lo    = m_lo;
        exp_start = !cxl && tb_is_long(op);
        lat       = exp_start ? op_latency(op) : 0;
        if (!cxl) model_apply(op, a, b);
        @(negedge clk);
        mdu_op = op;
        op_a   = a;
        op_b   = b;
        cancel = cxl;
        #1 check({tag, ".start"}, {31'd0, start}, {31'd0, exp_start});
        @(posedge clk);
        #1;
        mdu_op = MDU_NOOP;
        cancel = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check({tag, ".busy"}, {31'd0, busy}, 32'd1);
            if (i == 0 || i == lat - 1) begin
                check({tag, ".hold_hi"}, hi, old_hi);
                check({tag, ".hold_lo"}, lo, old_lo);
            end
            @(posedge clk);
            #1;
        end
        check({tag, ".idle"}, {31'd0, busy}, 32'd0);
        check({tag, ".hi"}, hi, m_hi);
        check({tag, ".lo"}, lo, m_lo);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic        rc;
        int          n_ops;

        reset  = 1'b0;
        mdu_op = MDU_NOOP;
        op_a   = 32'd0;
        op_b   = 32'd0;
        cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy",  {31'd0, busy},  32'd0);
        check("rst.start", {31'd0, start}, 32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Signed and unsigned multiply
        do_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult");
        check("mult.hi_lit", hi, 32'hFFFF_FFFF);
        check("mult.lo_lit", lo, 32'hFFFF_FFFE);
        do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
        check("multu.hi_lit", hi, 32'h0000_0001);
        check("multu.lo_lit", lo, 32'hFFFF_FFFE);

        // Divides including the overflow corner
        do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
        check("div.lo_lit", lo, 32'hFFFF_FFFD);
        check("div.hi_lit", hi, 32'hFFFF_FFFF);
        do_op(MDU_DIVU, 32'd7, 32'd2, 1'b0, "divu");
        check("divu.lo_lit", lo, 32'd3);
        check("divu.hi_lit", hi, 32'd1);
        do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divovf");
        check("divovf.lo_lit", lo, 32'h8000_0000);
        check("divovf.hi_lit", hi, 32'd0);

        // Divide by zero keeps HI/LO
        do_op(MDU_MTHI, 32'h11, 32'd0, 1'b0, "mthi11");
        do_op(MDU_MTLO, 32'h22, 32'd0, 1'b0, "mtlo22");
        do_op(MDU_DIV, 32'd5, 32'd0, 1'b0, "divz");
        check("divz.hi_lit", hi, 32'h11);
        check("divz.lo_lit", lo, 32'h22);
        do_op(MDU_DIVU, 32'd9, 32'd0, 1'b0, "divuz");

        // Cancelled issue, move-to, and an op arriving while busy
        do_op(MDU_MULT, 32'd3, 32'd3, 1'b1, "cxl");
        do_op(MDU_MTHI, 32'h1234, 32'd0, 1'b0, "mthi");
        check("mthi.lit", hi, 32'h1234);
        model_apply(MDU_MULT, 32'd3, 32'd4);
        @(negedge clk);
        mdu_op = MDU_MULT;
        op_a   = 32'd3;
        op_b   = 32'd4;
        @(posedge clk);
        #1;
        mdu_op = MDU_MTLO;
        op_a   = 32'hDEAD;
        #1 check("busy_mtlo.start", {31'd0, start}, 32'd0);
        @(posedge clk);
        #1;
        mdu_op = MDU_NOOP;
        check("busy_mtlo.busy", {31'd0, busy}, 32'd1);
        check("busy_mtlo.lo_hold", lo, 32'h22);
        repeat (MULT_N - 1) @(posedge clk);
        #1;
        check("busy_mtlo.idle", {31'd0, busy}, 32'd0);
        check("busy_mtlo.lo", lo, 32'd12);
        check("busy_mtlo.hi", hi, 32'd0);

        // Reset asserted during busy cycle 3 of a MULT
        @(negedge clk);
        mdu_op = MDU_MULT;
        op_a   = 32'd5;
        op_b   = 32'd6;
        @(posedge clk);
        #1;
        mdu_op = MDU_NOOP;
        repeat (2) @(posedge clk);
        #2;
        check("midrst.busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst.busy", {31'd0, busy}, 32'd0);
        check("midrst.hi", hi, 32'd0);
        check("midrst.lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        repeat (MULT_N + 2) @(posedge clk);
        #1;
        check("midrst.late_busy", {31'd0, busy}, 32'd0);
        check("midrst.late_hi", hi, 32'd0);
        check("midrst.late_lo", lo, 32'd0);

        // Multiply-accumulate code with and without the feature
        do_op(MDU_MTHI, 32'd0, 32'd0, 1'b0, "madd_prehi");
        do_op(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, "madd_prelo");
        do_op(MDU_MADDU, 32'd1, 32'd1, 1'b0, "maddu");
`ifdef MDU_MADD_EN
        check("maddu.hi_lit", hi, 32'd1);
        check("maddu.lo_lit", lo, 32'd0);
`else
        check("maddu.hi_lit", hi, 32'd0);
        check("maddu.lo_lit", lo, 32'hFFFF_FFFF);
`endif

        // Randomized traffic against the model
`ifdef MDU_MADD_EN
        n_ops = 10;
`else
        n_ops = 6;
`endif
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, n_ops - 1))
                0:       rop = MDU_MULT;
                1:       rop = MDU_MULTU;
                2:       rop = MDU_DIV;
                3:       rop = MDU_DIVU;
                4:       rop = MDU_MTHI;
                5:       rop = MDU_MTLO;
                6:       rop = MDU_MADD;
                7:       rop = MDU_MADDU;
                8:       rop = MDU_MSUB;
                default: rop = MDU_MSUBU;
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            rc = ($urandom_range(0, 5) == 0);
            do_op(rop, ra, rb, rc, $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
